game_seq_ctrl: RTL

Frame-rate game sequencer for the avoid-ball design. It owns the game state machine (idle, play, hit recovery, game over, optional pause), scores survival time, tracks lives and difficulty level, and schedules ball spawns. It sits between the debounce block and the drawing module: it consumes key pulses, the vsync line and the drawing module's collision flag, and it drives the run/speed/spawn controls back into the drawing module.

---
 rtl/game_seq_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: frame-rate sequencer for the avoid-ball game (state, score, lives, level, spawns).
// Define GAME_SEQ_PAUSE_EN to build in the PAUSE state and the key_pulse[4] pause toggle.
module game_seq_ctrl #(
   parameter int unsigned LIVES_INIT       = 3,
   parameter int unsigned FRAMES_PER_POINT = 60,
   parameter int unsigned LEVEL_PTS        = 10,
   parameter int unsigned HIT_FRAMES       = 90,
   parameter int unsigned SPAWN_BASE       = 64,
   parameter int unsigned BASE_STEP        = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic [4:0]  key_pulse,
   input  logic        collision,
   output logic [2:0]  state,
   output logic        run,
   output logic [3:0]  ball_step,
   output logic        spawn_req,
   output logic [13:0] score,
   output logic [1:0]  lives,
   output logic [2:0]  level,
   output logic        flash
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_HIT   = 3'd2,
      ST_OVER  = 3'd3,
      ST_PAUSE = 3'd4
   } state_e;

   localparam logic [15:0] FPP_LAST  = 16'(FRAMES_PER_POINT - 1);
   localparam logic [15:0] LVL_LAST  = 16'(LEVEL_PTS - 1);
   localparam logic [15:0] HIT_LAST  = 16'(HIT_FRAMES - 1);
   localparam logic [13:0] SCORE_MAX = 14'd9999;

   state_e      state_q, state_d;
   logic        vsync_q;
   logic        tick_q, tick_d;
   logic        run_q, run_d;
   logic        spawn_req_q, spawn_req_d;
   logic        flash_q, flash_d;
   logic [13:0] score_q, score_d;
   logic [1:0]  lives_q, lives_d;
   logic [2:0]  level_q, level_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] spawn_cnt_q, spawn_cnt_d;
   logic [15:0] pts_cnt_q, pts_cnt_d;
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] spawn_last_s;
   logic        adv_s;

`ifdef GAME_SEQ_PAUSE_EN
   state_e      ret_state_q, ret_state_d;
   logic        unused_keys_s;
   assign unused_keys_s = ^key_pulse[3:1];
`else
   logic        unused_keys_s;
   assign unused_keys_s = ^key_pulse[4:1];
`endif

   // Spawn period shrinks by 8 frames per level; compare against period-1.
   assign spawn_last_s = 16'(SPAWN_BASE) - {10'd0, level_q, 3'd0} - 16'd1;

   assign state     = state_q;
   assign run       = run_q;
   assign spawn_req = spawn_req_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign level     = level_q;
   assign flash     = flash_q;
   assign ball_step = 4'(BASE_STEP) + {1'b0, level_q};

   always_comb begin
      state_d     = state_q;
      tick_d      = vsync_q & ~vsync;
      score_d     = score_q;
      lives_d     = lives_q;
      level_d     = level_q;
      frame_cnt_d = frame_cnt_q;
      spawn_cnt_d = spawn_cnt_q;
      pts_cnt_d   = pts_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      spawn_req_d = 1'b0;
      adv_s       = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      ret_state_d = ret_state_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (key_pulse[0]) begin
               state_d     = ST_PLAY;
               score_d     = 14'd0;
               lives_d     = 2'(LIVES_INIT);
               level_d     = 3'd0;
               frame_cnt_d = 16'd0;
               spawn_cnt_d = 16'd0;
               pts_cnt_d   = 16'd0;
               hit_cnt_d   = 16'd0;
            end
         end
         ST_PLAY: begin
            // Collision beats both the pause key and a same-cycle tick.
            if (collision) begin
               if (lives_q == 2'd1) begin
                  lives_d = 2'd0;
                  state_d = ST_OVER;
               end else begin
                  lives_d   = lives_q - 2'd1;
                  hit_cnt_d = 16'd0;
                  state_d   = ST_HIT;
               end
            end
`ifdef GAME_SEQ_PAUSE_EN
            else if (key_pulse[4]) begin
               ret_state_d = ST_PLAY;
               state_d     = ST_PAUSE;
            end
`endif
            else begin
               adv_s = tick_q;
            end
         end
         ST_HIT: begin
`ifdef GAME_SEQ_PAUSE_EN
            if (key_pulse[4]) begin
               ret_state_d = ST_HIT;
               state_d     = ST_PAUSE;
            end else
`endif
            if (tick_q) begin
               adv_s = 1'b1;
               if (hit_cnt_q >= HIT_LAST) begin
                  hit_cnt_d = 16'd0;
                  state_d   = ST_PLAY;
               end else begin
                  hit_cnt_d = hit_cnt_q + 16'd1;
               end
            end
         end
         ST_OVER: begin
            if (key_pulse[0]) begin
               state_d = ST_IDLE;
            end
         end
`ifdef GAME_SEQ_PAUSE_EN
         ST_PAUSE: begin
            if (key_pulse[4]) begin
               state_d = ret_state_q;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (adv_s) begin
         if (frame_cnt_q >= FPP_LAST) begin
            frame_cnt_d = 16'd0;
            score_d     = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
            if (pts_cnt_q >= LVL_LAST) begin
               pts_cnt_d = 16'd0;
               level_d   = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
            end else begin
               pts_cnt_d = pts_cnt_q + 16'd1;
            end
         end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
         // >= keeps the wrap safe when a level-up shortens the period mid-count.
         if (spawn_cnt_q >= spawn_last_s) begin
            spawn_cnt_d = 16'd0;
            spawn_req_d = 1'b1;
         end else begin
            spawn_cnt_d = spawn_cnt_q + 16'd1;
         end
      end

      run_d = (state_d == ST_PLAY) || (state_d == ST_HIT);
      if (state_d == ST_HIT) begin
         flash_d = hit_cnt_d[2];
      end else if (state_d == ST_PAUSE) begin
         flash_d = flash_q;
      end else begin
         flash_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vsync_q     <= 1'b1;
         tick_q      <= 1'b0;
         run_q       <= 1'b0;
         spawn_req_q <= 1'b0;
         flash_q     <= 1'b0;
         score_q     <= 14'd0;
         lives_q     <= 2'(LIVES_INIT);
         level_q     <= 3'd0;
         frame_cnt_q <= 16'd0;
         spawn_cnt_q <= 16'd0;
         pts_cnt_q   <= 16'd0;
         hit_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= vsync;
         tick_q      <= tick_d;
         run_q       <= run_d;
         spawn_req_q <= spawn_req_d;
         flash_q     <= flash_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         frame_cnt_q <= frame_cnt_d;
         spawn_cnt_q <= spawn_cnt_d;
         pts_cnt_q   <= pts_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
      end
   end

`ifdef GAME_SEQ_PAUSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_state_q <= ST_PLAY;
      end else begin
         ret_state_q <= ret_state_d;
      end
   end
`endif

endmodule
